fm_wb_arbiter: RTL
==================

// Module: fm_wb_arbiter
// PURPOSE
//  Shares the single write port of one column's ping-pong feature-map buffer among the NUM_REQ PE-row write-back requesters.
//  Per layer: accepts write-back bytes from each row, places each row's output in a fixed address region, then swaps the ping-pong bank.
//  Sits between the PE matrix write-back outputs (data/valid/ready) and the fm ping_pong_buffer write side (addra/dina/wea/ping_pong).
// PARAMETERS
//  NUM_REQ   4     number of requesters (PE rows)
//  DATA_W    8     write-back word width
//  DEPTH     1024  fm buffer depth in words; must be a power of 2 and divisible by NUM_REQ
//  ADDR_W    $clog2(DEPTH)        buffer address width (derived)
//  REGION_W  ADDR_W-$clog2(NUM_REQ)  per-requester region address width (derived)
// PORTS
//  clk            in   1                 clock, all logic on rising edge
//  rst            in   1                 asynchronous, active-high reset
//  start_i        in   1                 layer start pulse; sampled in IDLE only
//  row_len_i      in   ADDR_W            words expected from each requester this layer
//  req_valid_i    in   NUM_REQ           per-requester data valid
//  req_data_i     in   NUM_REQ*DATA_W    per-requester data; requester k uses bits [k*DATA_W +: DATA_W]
//  req_ready_o    out  NUM_REQ           per-requester ready; at most one bit high (one-hot or zero)
//  buf_wr_en_o    out  1                 buffer write enable
//  buf_wr_addr_o  out  ADDR_W            buffer write address
//  buf_din_o      out  DATA_W            buffer write data
//  ping_pong_o    out  1                 bank select to the buffer
//  busy_o         out  1                 high in RUN and SWAP
//  done_o         out  1                 one-cycle pulse at layer completion
//  len_err_o      out  1                 sticky flag: row_len_i exceeded the region size
// BEHAVIOUR
//  Reset values: req_ready_o=0, buf_wr_en_o=0, buf_wr_addr_o=0, buf_din_o=0, ping_pong_o=0, busy_o=0, done_o=0,
//   len_err_o=0, state=IDLE, all counts=0, RR pointer=0. A reset mid-layer aborts it; no write is issued after reset.
//  FSM IDLE -> RUN on start_i:
//   - latch len = min(row_len_i, 2**REGION_W)
//   - if row_len_i > 2**REGION_W, set len_err_o (stays set until rst)
//   - clear count[k] for every requester
//  Eligible requester: req_valid_i[k] && count[k] < len.
//  RUN, arbitration (combinational, same cycle):
//   - grant the first eligible requester at or after rr_ptr, scanning upward and wrapping past NUM_REQ-1 to 0
//   - req_ready_o = one-hot of the grant; all zero if no requester is eligible
//   - a requester with count[k]==len never gets ready, even while its valid is high
//  RUN, on transfer (valid && ready for granted g), registered with 1-cycle latency:
//   - buf_wr_en_o=1, buf_wr_addr_o={g[$clog2(NUM_REQ)-1:0], count[g][REGION_W-1:0]}, buf_din_o=data[g]
//   - count[g]++, rr_ptr=(g+1) mod NUM_REQ
//   - no transfer in a cycle => buf_wr_en_o=0 the next cycle; addr/data hold their last values
//  Throughput: one word per cycle. A requester that stays valid and is alone gets back-to-back grants.
//  RUN -> SWAP when every count[k]==len, evaluated on the updated counts; the last write is still issued.
//  SWAP (one cycle): ping_pong_o toggles, done_o=1, req_ready_o=0, then -> IDLE.
//  len==0: RUN lasts one cycle with no grant, then SWAP; the bank still toggles and done_o still pulses.
//  start_i while in RUN or SWAP is ignored. start_i arriving in the SWAP cycle is dropped; the controller re-issues it.
//  busy_o is high exactly while state is RUN or SWAP.
// CONFIGURATION
//  Macro FM_WB_ARB_PERF_EN:
//   - defined: adds output stall_cnt_o [31:0]. Cleared on entry to RUN; +1 in every RUN cycle in which some
//     req_valid_i bit is high but that requester gets no ready; saturates at 2**32-1; held in IDLE.
//   - undefined: the port and counter do not exist; all other behaviour is identical.
// TESTING
//  1. NUM_REQ=4, len=3, all valid held high -> grants 0,1,2,3,0,1,2,3,0,1,2,3; addrs 0,256,512,768,1,257,...,770; then done_o pulses, ping_pong_o 0->1.
//  2. Only req2 valid, len=5 -> 5 back-to-back writes at addrs 512..516 with wea 1 cycle after each handshake; no done until other rows also finish.
//  3. row_len_i=300 (region 256) -> len_err_o=1; each row writes exactly 256 words; layer completes normally.
//  4. row_len_i=0 -> done_o pulses 2 cycles after start_i; no buf_wr_en_o; ping_pong_o toggles.
//  5. rst asserted mid-RUN after 5 writes -> all outputs go to reset values on the same edge; a new start_i starts the counts from 0.
//  6. PERF_EN defined, req0 and req1 valid continuously, len=4 -> stall_cnt_o=8 at done_o (1 stall per cycle for 8 cycles).

Source files
------------

// File: rtl/fm_wb_arbiter.sv
// Write-back arbiter: round-robin sharing of one ping-pong feature-map buffer write port among PE rows.
// Optional stall counter output enabled by defining FM_WB_ARB_PERF_EN.
module fm_wb_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int REGION_W = ADDR_W - $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [ADDR_W-1:0]         row_len_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      buf_wr_en_o,
  output logic [ADDR_W-1:0]         buf_wr_addr_o,
  output logic [DATA_W-1:0]         buf_din_o,
  output logic                      ping_pong_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      len_err_o
`ifdef FM_WB_ARB_PERF_EN
  ,output logic [31:0]              stall_cnt_o
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [ADDR_W:0] REGION_SIZE = {{ADDR_W{1'b0}}, 1'b1} << REGION_W;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, SWAP = 2'd2} state_t;

  state_t              state_r, state_next_s;
  logic [ADDR_W-1:0]   len_r;
  logic [ADDR_W-1:0]   count_r      [NUM_REQ];
  logic [ADDR_W-1:0]   count_next_s [NUM_REQ];
  logic [PTR_W-1:0]    rr_ptr_r;
  logic [NUM_REQ-1:0]  eligible_s;
  logic [NUM_REQ-1:0]  grant_s;
  logic [PTR_W-1:0]    grant_idx_s;
  logic [PTR_W-1:0]    idx_s;
  logic                found_s;
  logic                xfer_s;
  logic                all_done_s;
  logic                too_long_s;
  logic                wr_en_r;
  logic [ADDR_W-1:0]   wr_addr_r;
  logic [DATA_W-1:0]   din_r;
  logic                ping_pong_r;
  logic                len_err_r;

  assign too_long_s = ({1'b0, row_len_i} > REGION_SIZE);
  assign xfer_s     = |grant_s;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // Eligibility and post-transfer counts; completion is judged on the updated counts
  always_comb begin
    all_done_s = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      eligible_s[k]   = (state_r == RUN) && req_valid_i[k] && (count_r[k] < len_r);
      count_next_s[k] = count_r[k] + {{(ADDR_W-1){1'b0}}, grant_s[k]};
      if (count_next_s[k] != len_r) all_done_s = 1'b0;
      else                          all_done_s = all_done_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = start_i ? RUN : IDLE;
      RUN:     state_next_s = all_done_s ? SWAP : RUN;
      SWAP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Output logic: round-robin grant scanning upward from rr_ptr with wrap
  always_comb begin
    grant_s     = '0;
    grant_idx_s = '0;
    found_s     = 1'b0;
    idx_s       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_s = rr_ptr_r + PTR_W'(i);
      if (!found_s && eligible_s[idx_s]) begin
        found_s        = 1'b1;
        grant_idx_s    = idx_s;
        grant_s[idx_s] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Layer bookkeeping and registered buffer write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r       <= '0;
      rr_ptr_r    <= '0;
      wr_en_r     <= 1'b0;
      wr_addr_r   <= '0;
      din_r       <= '0;
      ping_pong_r <= 1'b0;
      len_err_r   <= 1'b0;
      for (int k = 0; k < NUM_REQ; k++) count_r[k] <= '0;
    end else begin
      wr_en_r <= xfer_s;
      if (xfer_s) begin
        wr_addr_r <= {grant_idx_s, count_r[grant_idx_s][REGION_W-1:0]};
        din_r     <= req_data_i[grant_idx_s*DATA_W +: DATA_W];
        rr_ptr_r  <= grant_idx_s + PTR_W'(1);
      end
      if (state_r == IDLE && start_i) begin
        len_r <= too_long_s ? REGION_SIZE[ADDR_W-1:0] : row_len_i;
        if (too_long_s) len_err_r <= 1'b1;
        for (int k = 0; k < NUM_REQ; k++) count_r[k] <= '0;
      end else if (state_r == RUN) begin
        for (int k = 0; k < NUM_REQ; k++) count_r[k] <= count_next_s[k];
      end
      if (state_r == RUN && state_next_s == SWAP) ping_pong_r <= ~ping_pong_r;
    end
  end

`ifdef FM_WB_ARB_PERF_EN
  logic [31:0] stall_cnt_r;

  // Cycles where a valid requester is left waiting, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 32'd0;
    end else if (state_r == IDLE && start_i) begin
      stall_cnt_r <= 32'd0;
    end else if (state_r == RUN && (|(req_valid_i & ~grant_s)) && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_r;
`endif

  assign req_ready_o   = grant_s;
  assign buf_wr_en_o   = wr_en_r;
  assign buf_wr_addr_o = wr_addr_r;
  assign buf_din_o     = din_r;
  assign ping_pong_o   = ping_pong_r;
  assign len_err_o     = len_err_r;
  assign busy_o        = (state_r != IDLE);
  assign done_o        = (state_r == SWAP);

endmodule
